// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM state type and lane helpers for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? 4'b0001 : f3[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (!we && ((f3 == F3_BU) || (f3 == F3_HU)));
  endfunction

  function automatic logic is_split(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == 2'b10 && off != 2'b00) || (f3[1:0] == 2'b01 && off == 2'b11);
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store byte-lane shift/mask and load shift/extend across two words
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word0_i,
  input  logic [31:0] word1_i,
  output logic [7:0]  mask_o,
  output logic [63:0] wvec_o,
  output logic [31:0] rdata_o
);
  logic [31:0] rvec;

  always_comb begin
    mask_o  = {4'b0000, size_mask(funct3_i)} << off_i;
    wvec_o  = {32'd0, wdata_i} << {off_i, 3'b000};
    rvec    = 32'({word1_i, word0_i} >> {off_i, 3'b000});
    rdata_o = funct3_i == F3_B  ? {{24{rvec[7]}}, rvec[7:0]}   :
              funct3_i == F3_H  ? {{16{rvec[15]}}, rvec[15:0]} :
              funct3_i == F3_BU ? {24'd0, rvec[7:0]}           :
              funct3_i == F3_HU ? {16'd0, rvec[15:0]}          : rvec;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator to word-organised data memory
// Misaligned accesses are split into two word accesses; mem outputs are registered.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS       = 9,
  parameter int DATA_W           = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [DM_ADDRESS-1:0] req_addr_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_W-1:0]     resp_rdata_o,
  output logic                  resp_err_o,
  output logic [DM_ADDRESS-1:0] mem_addr_o,
  output logic                  mem_re_o,
  output logic [3:0]            mem_wr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i
);
  state_t                state_q;
  logic                  we_q, split_q, err_q, mem_re_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [3:0]            mask_hi_q, mem_wr_q;
  logic [DATA_W-1:0]     word0_q, wdata_hi_q, mem_wdata_q;
  logic [DM_ADDRESS-1:0] mem_addr_q;
  logic                  split_d, err_d;
  logic [7:0]            mask;
  logic [63:0]           wvec;
  logic [DATA_W-1:0]     al_rdata;

  // In IDLE the aligner sees the incoming request; afterwards the latched one
  lsu_lane_align u_align (
    .funct3_i (state_q == IDLE ? req_funct3_i : f3_q),
    .off_i    (state_q == IDLE ? req_addr_i[1:0] : off_q),
    .wdata_i  (req_wdata_i),
    .word0_i  (split_q ? word0_q : mem_rdata_i),
    .word1_i  (mem_rdata_i),
    .mask_o   (mask),
    .wvec_o   (wvec),
    .rdata_o  (al_rdata)
  );

  always_comb begin
    split_d = is_split(req_funct3_i, req_addr_i[1:0]);
    err_d   = !f3_legal(req_we_i, req_funct3_i) || (ALLOW_MISALIGNED == 0 && split_d);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      split_q     <= 1'b0;
      err_q       <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      mask_hi_q   <= '0;
      word0_q     <= '0;
      wdata_hi_q  <= '0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_wr_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_re_q <= 1'b0;
      mem_wr_q <= '0;
      case (state_q)
        IDLE: if (req_valid_i) begin
          we_q       <= req_we_i;
          f3_q       <= req_funct3_i;
          off_q      <= req_addr_i[1:0];
          split_q    <= split_d;
          err_q      <= err_d;
          mask_hi_q  <= mask[7:4];
          wdata_hi_q <= wvec[63:32];
          if (err_d) state_q <= RESP;
          else begin
            state_q     <= ACC0;
            mem_addr_q  <= {req_addr_i[DM_ADDRESS-1:2], 2'b00};
            mem_re_q    <= !req_we_i;
            mem_wr_q    <= req_we_i ? mask[3:0] : 4'b0000;
            mem_wdata_q <= wvec[31:0];
          end
        end
        ACC0: if (split_q) begin
          state_q     <= ACC1;
          mem_addr_q  <= mem_addr_q + DM_ADDRESS'(4);
          mem_re_q    <= !we_q;
          mem_wr_q    <= we_q ? mask_hi_q : 4'b0000;
          mem_wdata_q <= wdata_hi_q;
        end else state_q <= RESP;
        ACC1: begin
          word0_q <= mem_rdata_i;
          state_q <= RESP;
        end
        RESP: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready_o  = state_q == IDLE;
    resp_valid_o = state_q == RESP;
    resp_err_o   = state_q == RESP && err_q;
    resp_rdata_o = (state_q == RESP && !err_q && !we_q) ? al_rdata : '0;
    mem_addr_o   = mem_addr_q;
    mem_re_o     = mem_re_q;
    mem_wr_o     = mem_wr_q;
    mem_wdata_o  = mem_wdata_q;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors against a byte-enabled word memory model
module tb_load_store_unit;
  logic        clk, rst;
  logic        req_valid, v_na, req_we;
  logic [2:0]  req_f3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata, mem_rdata;
  logic        req_ready, resp_valid, resp_err, mem_re;
  logic [31:0] resp_rdata, mem_wdata;
  logic [8:0]  mem_addr;
  logic [3:0]  mem_wr;
  logic        rdy_n, rv_n, err_n, re_n;
  logic [31:0] rd_n, wd_n;
  logic [8:0]  ad_n;
  logic [3:0]  wr_n;
  logic [31:0] m [128];
  int n_cmp = 0, n_bad = 0;

  load_store_unit dut (
    .clk_i(clk), .reset_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_funct3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_addr_o(mem_addr), .mem_re_o(mem_re), .mem_wr_o(mem_wr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  load_store_unit #(.ALLOW_MISALIGNED(0)) dut_na (
    .clk_i(clk), .reset_i(rst), .req_valid_i(v_na), .req_ready_o(rdy_n),
    .req_we_i(req_we), .req_funct3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(rv_n), .resp_rdata_o(rd_n), .resp_err_o(err_n),
    .mem_addr_o(ad_n), .mem_re_o(re_n), .mem_wr_o(wr_n), .mem_wdata_o(wd_n),
    .mem_rdata_i(32'h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 128; i++) m[i] <= 32'h0;
    m[0]   <= 32'h55667788;
    m[4]   <= 32'h8899AABB;
    m[5]   <= 32'h11223344;
    m[127] <= 32'hA1B2C3D4;
    mem_rdata <= 32'h0;
    forever begin
      @(posedge clk);
      if (mem_wr[0]) m[mem_addr[8:2]][7:0]   <= mem_wdata[7:0];
      if (mem_wr[1]) m[mem_addr[8:2]][15:8]  <= mem_wdata[15:8];
      if (mem_wr[2]) m[mem_addr[8:2]][23:16] <= mem_wdata[23:16];
      if (mem_wr[3]) m[mem_addr[8:2]][31:24] <= mem_wdata[31:24];
      if (mem_re) mem_rdata <= m[mem_addr[8:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [8:0] a,
                       input logic [31:0] d, input logic na);
    int k = 0;
    @(negedge clk);
    while (!(na ? rdy_n : req_ready) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) check("ready_timeout", {31'd0, na ? rdy_n : req_ready}, 32'd1);
    req_we = we; req_f3 = f3; req_addr = a; req_wdata = d;
    if (na) v_na = 1'b1; else req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; v_na = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; v_na = 1'b0; req_we = 1'b0;
    req_f3 = 3'b0; req_addr = 9'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_mem_re", {31'd0, mem_re}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_mem_wr", {28'd0, mem_wr}, 32'd0);
    check("post_rst_addr", {23'd0, mem_addr}, 32'd0);

    issue(1'b0, 3'b000, 9'h013, 32'h0, 1'b0);
    @(negedge clk);
    check("lb_addr", {23'd0, mem_addr}, 32'h10);
    check("lb_re", {31'd0, mem_re}, 32'd1);
    check("lb_busy", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("lb_valid", {31'd0, resp_valid}, 32'd1);
    check("lb_data", resp_rdata, 32'hFFFFFF88);

    issue(1'b0, 3'b100, 9'h013, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    check("lbu_data", resp_rdata, 32'h00000088);

    issue(1'b0, 3'b001, 9'h012, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    check("lh_data", resp_rdata, 32'hFFFF8899);

    issue(1'b0, 3'b010, 9'h012, 32'h0, 1'b0);
    @(negedge clk);
    check("lw_split_a0", {23'd0, mem_addr}, 32'h10);
    @(negedge clk);
    check("lw_split_a1", {23'd0, mem_addr}, 32'h14);
    check("lw_split_noresp", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check("lw_split_valid", {31'd0, resp_valid}, 32'd1);
    check("lw_split_data", resp_rdata, 32'h33448899);
    check("lw_split_err", {31'd0, resp_err}, 32'd0);

    issue(1'b1, 3'b001, 9'h013, 32'h0000CAFE, 1'b0);
    @(negedge clk);
    check("sh_wr0", {28'd0, mem_wr}, 32'b1000);
    check("sh_b3", {24'd0, mem_wdata[31:24]}, 32'hFE);
    check("sh_re0", {31'd0, mem_re}, 32'd0);
    @(negedge clk);
    check("sh_wr1", {28'd0, mem_wr}, 32'b0001);
    check("sh_b0", {24'd0, mem_wdata[7:0]}, 32'hCA);
    check("sh_a1", {23'd0, mem_addr}, 32'h14);
    @(negedge clk);
    check("sh_valid", {31'd0, resp_valid}, 32'd1);
    check("sh_rdata", resp_rdata, 32'h0);

    issue(1'b0, 3'b101, 9'h013, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("lhu_split", resp_rdata, 32'h0000CAFE);

    issue(1'b0, 3'b010, 9'h1FE, 32'h0, 1'b0);
    @(negedge clk);
    check("wrap_a0", {23'd0, mem_addr}, 32'h1FC);
    @(negedge clk);
    check("wrap_a1", {23'd0, mem_addr}, 32'h000);
    @(negedge clk);
    check("wrap_data", resp_rdata, 32'h7788A1B2);

    issue(1'b0, 3'b011, 9'h010, 32'h0, 1'b0);
    @(negedge clk);
    check("ill_valid", {31'd0, resp_valid}, 32'd1);
    check("ill_err", {31'd0, resp_err}, 32'd1);
    check("ill_rdata", resp_rdata, 32'h0);
    check("ill_re", {31'd0, mem_re}, 32'd0);

    issue(1'b1, 3'b100, 9'h010, 32'h12345678, 1'b0);
    @(negedge clk);
    check("ill_st_err", {31'd0, resp_err}, 32'd1);
    check("ill_st_wr", {28'd0, mem_wr}, 32'd0);

    issue(1'b0, 3'b010, 9'h012, 32'h0, 1'b1);
    @(negedge clk);
    check("na_valid", {31'd0, rv_n}, 32'd1);
    check("na_err", {31'd0, err_n}, 32'd1);
    check("na_re", {31'd0, re_n}, 32'd0);

    issue(1'b0, 3'b001, 9'h011, 32'h0, 1'b1);
    @(negedge clk);
    check("na_lh_re", {31'd0, re_n}, 32'd1);
    @(negedge clk);
    check("na_lh_valid", {31'd0, rv_n}, 32'd1);
    check("na_lh_err", {31'd0, err_n}, 32'd0);

    issue(1'b0, 3'b010, 9'h012, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    check("rstmid_re", {31'd0, mem_re}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_re0", {31'd0, mem_re}, 32'd0);
    check("rstmid_addr0", {23'd0, mem_addr}, 32'd0);
    check("rstmid_valid0", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_novalid", {31'd0, resp_valid}, 32'd0);
    check("rstmid_ready", {31'd0, req_ready}, 32'd1);

    issue(1'b1, 3'b010, 9'h020, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check("sw_wr", {28'd0, mem_wr}, 32'b1111);
    check("sw_wdata", mem_wdata, 32'hDEADBEEF);
    check("sw_addr", {23'd0, mem_addr}, 32'h20);
    @(negedge clk);
    check("sw_valid", {31'd0, resp_valid}, 32'd1);
    check("sw_err", {31'd0, resp_err}, 32'd0);
    check("sw_mem", m[8], 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
